// File: rtl/i2c_target.sv
// i2c_target: 7-bit-address I2C target (responder).
// SCL/SDA are oversampled on clk; START/STOP/edge events are derived from the
// synchronised copies, and SDA is only ever pulled low or released.
// Optional feature macro: I2C_TARGET_GENERAL_CALL_EN -- when defined, the
// general-call address byte 8'h00 (write) is ACKed like the own address.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | bus free, waiting for START
// ADDR     | shifting in the 8-bit address byte
// ADDR_ACK | address matched: drive ACK on the next SCL low phase
// RX_BYTE  | write transfer, shifting in a data byte
// RX_ACK   | write transfer, driving ACK for the byte just received
// TX_BYTE  | read transfer, presenting data bits on each SCL fall
// TX_ACK   | read transfer, sampling the controller's ACK/NACK
// IGNORE   | not addressed or read ended by NACK; wait for START/STOP
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int          SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       I2C_SCL,
  inout  logic       I2C_SDA_t,
  input  logic [7:0] TX_DATA,
  output logic       TX_LOAD,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       ADDR_HIT,
  output logic       RW,
  output logic       BUSY
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, IGNORE
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_q, sda_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_evt, stop_evt;

  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [6:0] tx_shift_q, tx_shift_d;
  logic       sda_oe_q, sda_oe_d;
  logic       tx_load_q, tx_load_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       addr_hit_q, addr_hit_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;

  logic [7:0] rx_byte;
  logic       addr_match;

  // Synchroniser chains plus one delayed copy for edge detection; preset to
  // the idle-bus level so leaving reset never looks like a bus event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], I2C_SCL};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], I2C_SDA_t};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_evt = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_evt  = scl_s & scl_q & ~sda_q & sda_s;

  assign rx_byte = {shift_q, sda_s};

`ifdef I2C_TARGET_GENERAL_CALL_EN
  assign addr_match = (rx_byte[7:1] == TARGET_ADDR) || (rx_byte == 8'h00);
`else
  assign addr_match = (rx_byte[7:1] == TARGET_ADDR);
`endif

  // State and datapath registers; reset releases SDA immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 7'd0;
      tx_shift_q <= 7'd0;
      sda_oe_q   <= 1'b0;
      tx_load_q  <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      addr_hit_q <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_shift_q <= tx_shift_d;
      sda_oe_q   <= sda_oe_d;
      tx_load_q  <= tx_load_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      addr_hit_q <= addr_hit_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state and output logic; START/STOP override any data event.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_shift_d = tx_shift_q;
    sda_oe_d   = sda_oe_q;
    tx_load_d  = 1'b0;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    addr_hit_d = addr_hit_q;
    rw_d       = rw_q;
    busy_d     = busy_q;

    if (stop_evt) begin
      state_d    = IDLE;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      addr_hit_d = 1'b0;
    end else if (start_evt) begin
      state_d    = ADDR;
      bit_cnt_d  = 4'd0;
      sda_oe_d   = 1'b0;
      addr_hit_d = 1'b0;
      busy_d     = 1'b1;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shift_d = rx_byte[6:0];
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (addr_match) begin
                state_d = ADDR_ACK;
                rw_d    = sda_s;
              end else begin
                state_d = IGNORE;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        // sda_oe_q distinguishes the first SCL fall (start ACK) from the second (end ACK).
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d   = 1'b1;
              addr_hit_d = 1'b1;
            end else if (rw_q) begin
              tx_shift_d = TX_DATA[6:0];
              tx_load_d  = 1'b1;
              sda_oe_d   = ~TX_DATA[7];
              bit_cnt_d  = 4'd0;
              state_d    = TX_BYTE;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = RX_BYTE;
            end
          end
        end
        RX_BYTE: begin
          if (scl_rise) begin
            shift_d = rx_byte[6:0];
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d  = 4'd0;
              rx_data_d  = rx_byte;
              rx_valid_d = 1'b1;
              state_d    = RX_ACK;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        RX_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = RX_BYTE;
            end
          end
        end
        TX_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              sda_oe_d  = 1'b0;
              state_d   = TX_ACK;
            end else begin
              bit_cnt_d  = bit_cnt_q + 4'd1;
              sda_oe_d   = ~tx_shift_q[6];
              tx_shift_d = {tx_shift_q[5:0], 1'b0};
            end
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            if (sda_s) state_d = IGNORE;
          end else if (scl_fall) begin
            tx_shift_d = TX_DATA[6:0];
            tx_load_d  = 1'b1;
            sda_oe_d   = ~TX_DATA[7];
            bit_cnt_d  = 4'd0;
            state_d    = TX_BYTE;
          end
        end
        IGNORE: sda_oe_d = 1'b0;
        default: ;
      endcase
    end
  end

  assign I2C_SDA_t = sda_oe_q ? 1'b0 : 1'bz;
  assign TX_LOAD   = tx_load_q;
  assign RX_DATA   = rx_data_q;
  assign RX_VALID  = rx_valid_q;
  assign ADDR_HIT  = addr_hit_q;
  assign RW        = rw_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bus-level controller model driving i2c_target at 100 kHz SCL
// with a 10 MHz system clock; expectations come from the bus protocol rules.
`timescale 1ns/1ps
module tb_i2c_target;

  localparam logic [6:0] TGT = 7'h42;
  localparam int QTR = 2500;
`ifdef I2C_TARGET_GENERAL_CALL_EN
  localparam bit GC_EN = 1'b1;
`else
  localparam bit GC_EN = 1'b0;
`endif

  logic       clk, rst_n, m_scl, m_sda_low;
  logic [7:0] tx_data;
  logic       tx_load, rx_valid, addr_hit, rw, busy;
  logic [7:0] rx_data;
  wire        sda_bus;

  pullup (sda_bus);
  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] rx_log[$];
  int tx_loads = 0;

  i2c_target #(.TARGET_ADDR(TGT), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .I2C_SCL(m_scl), .I2C_SDA_t(sda_bus),
    .TX_DATA(tx_data), .TX_LOAD(tx_load), .RX_DATA(rx_data), .RX_VALID(rx_valid),
    .ADDR_HIT(addr_hit), .RW(rw), .BUSY(busy)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  always @(negedge clk) begin
    if (rx_valid) rx_log.push_back(rx_data);
    if (tx_load) tx_loads++;
  end

  // Expected address acceptance straight from the addressing rules.
  function automatic logic model_addr_ack(input logic [7:0] ab);
    return (ab[7:1] == TGT) || (GC_EN && (ab == 8'h00));
  endfunction

  task automatic bus_start();
    #QTR m_sda_low = 1'b1;
    #QTR m_scl = 1'b0;
  endtask

  task automatic bus_rstart();
    #QTR m_sda_low = 1'b0;
    #QTR m_scl = 1'b1;
    #QTR m_sda_low = 1'b1;
    #QTR m_scl = 1'b0;
  endtask

  task automatic bus_stop();
    #QTR m_sda_low = 1'b1;
    #QTR m_scl = 1'b1;
    #QTR m_sda_low = 1'b0;
    #QTR;
  endtask

  task automatic bus_bit(input logic b, output logic s);
    #QTR m_sda_low = ~b;
    #QTR m_scl = 1'b1;
    #QTR s = sda_bus;
    #QTR m_scl = 1'b0;
  endtask

  task automatic bus_write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
    bus_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic bus_read_byte(input logic [7:0] next_tx, input logic m_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      d[i] = s;
      if (i == 7) tx_data = next_tx;
    end
    bus_bit(~m_ack, s);
  endtask

  task automatic test_reset();
    logic [13:0] obs;
    repeat (4) @(posedge clk);
    #13;
    obs = {sda_bus, tx_load, rx_data, rx_valid, addr_hit, rw, busy};
    n_checks++;
    if (obs !== 14'b1_0_00000000_0_0_0_0) $display("FAIL reset_in: got %b want %b", obs, 14'b1_0_00000000_0_0_0_0);
    else n_pass++;
    rst_n = 1'b1;
    #1000;
    obs = {sda_bus, tx_load, rx_data, rx_valid, addr_hit, rw, busy};
    n_checks++;
    if (obs !== 14'b1_0_00000000_0_0_0_0) $display("FAIL reset_out: got %b want %b", obs, 14'b1_0_00000000_0_0_0_0);
    else n_pass++;
  endtask

  task automatic test_write();
    logic ack;
    int base;
    base = rx_log.size();
    bus_start();
    n_checks++; if (busy !== 1'b1) $display("FAIL wr_busy: got %b want 1", busy); else n_pass++;
    bus_write_byte(8'h84, ack);
    n_checks++; if (ack !== 1'b1) $display("FAIL wr_addr_ack: got %b want 1", ack); else n_pass++;
    n_checks++; if ({addr_hit, rw} !== 2'b10) $display("FAIL wr_hit_rw: got %b want 10", {addr_hit, rw}); else n_pass++;
    bus_write_byte(8'hA5, ack);
    n_checks++; if (ack !== 1'b1) $display("FAIL wr_d0_ack: got %b want 1", ack); else n_pass++;
    bus_write_byte(8'h3C, ack);
    n_checks++; if (ack !== 1'b1) $display("FAIL wr_d1_ack: got %b want 1", ack); else n_pass++;
    bus_stop();
    n_checks++; if ({addr_hit, busy} !== 2'b00) $display("FAIL wr_stop: got hit/busy %b want 00", {addr_hit, busy}); else n_pass++;
    n_checks++;
    if (rx_log.size() - base != 2) $display("FAIL wr_rx_count: got %0d want 2", rx_log.size() - base);
    else if (rx_log[base] !== 8'hA5 || rx_log[base+1] !== 8'h3C)
      $display("FAIL wr_rx_data: got %h %h want a5 3c", rx_log[base], rx_log[base+1]);
    else n_pass++;
  endtask

  task automatic test_read();
    logic ack;
    logic [7:0] d;
    int base;
    base = tx_loads;
    tx_data = 8'h5A;
    bus_start();
    bus_write_byte(8'h85, ack);
    n_checks++; if (ack !== 1'b1) $display("FAIL rd_addr_ack: got %b want 1", ack); else n_pass++;
    n_checks++; if (rw !== 1'b1) $display("FAIL rd_rw: got %b want 1", rw); else n_pass++;
    bus_read_byte(8'hC3, 1'b1, d);
    n_checks++; if (d !== 8'h5A) $display("FAIL rd_byte0: got %h want 5a", d); else n_pass++;
    bus_read_byte(8'h00, 1'b0, d);
    n_checks++; if (d !== 8'hC3) $display("FAIL rd_byte1: got %h want c3", d); else n_pass++;
    #QTR;
    n_checks++; if (sda_bus !== 1'b1) $display("FAIL rd_release_nack: got %b want 1", sda_bus); else n_pass++;
    n_checks++; if (addr_hit !== 1'b1) $display("FAIL rd_hit_before_stop: got %b want 1", addr_hit); else n_pass++;
    bus_stop();
    n_checks++; if (tx_loads - base != 2) $display("FAIL rd_tx_loads: got %0d want 2", tx_loads - base); else n_pass++;
    n_checks++; if ({addr_hit, busy, rw} !== 3'b001) $display("FAIL rd_stop: got hit/busy/rw %b want 001", {addr_hit, busy, rw}); else n_pass++;
  endtask

  task automatic test_nomatch();
    logic ack;
    int base;
    base = rx_log.size();
    bus_start();
    bus_write_byte(8'h90, ack);
    n_checks++; if (ack !== 1'b0) $display("FAIL nm_addr_ack: got %b want 0", ack); else n_pass++;
    bus_write_byte(8'hFF, ack);
    n_checks++; if (ack !== 1'b0) $display("FAIL nm_data_ack: got %b want 0", ack); else n_pass++;
    n_checks++; if ({busy, addr_hit} !== 2'b10) $display("FAIL nm_busy_hit: got %b want 10", {busy, addr_hit}); else n_pass++;
    bus_stop();
    n_checks++; if (busy !== 1'b0) $display("FAIL nm_stop_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (rx_log.size() != base) $display("FAIL nm_rx_count: got %0d want 0", rx_log.size() - base); else n_pass++;
  endtask

  task automatic test_repeated_start();
    logic ack;
    logic [7:0] d, r;
    int base;
    base = rx_log.size();
    r = 8'($urandom);
    bus_start();
    bus_write_byte(8'h84, ack);
    n_checks++; if (ack !== 1'b1) $display("FAIL rs_addr0_ack: got %b want 1", ack); else n_pass++;
    bus_write_byte(8'h11, ack);
    n_checks++; if ({ack, rw} !== 2'b10) $display("FAIL rs_data_ack_rw: got %b want 10", {ack, rw}); else n_pass++;
    tx_data = r;
    bus_rstart();
    n_checks++; if ({busy, addr_hit} !== 2'b10) $display("FAIL rs_busy_hit: got %b want 10", {busy, addr_hit}); else n_pass++;
    bus_write_byte(8'h85, ack);
    n_checks++; if ({ack, rw, addr_hit} !== 3'b111) $display("FAIL rs_addr1: got ack/rw/hit %b want 111", {ack, rw, addr_hit}); else n_pass++;
    bus_read_byte(8'h00, 1'b0, d);
    n_checks++; if (d !== r) $display("FAIL rs_read: got %h want %h", d, r); else n_pass++;
    bus_stop();
    n_checks++;
    if (rx_data !== 8'h11 || rx_log.size() - base != 1)
      $display("FAIL rs_rx: got %h (count %0d) want 11 (count 1)", rx_data, rx_log.size() - base);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic ack, s;
    logic [7:0] d;
    logic [13:0] obs;
    int base;
    d = 8'($urandom);
    bus_start();
    bus_write_byte(8'h84, ack);
    for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
    #QTR m_sda_low = 1'b0;
    #1;
    n_checks++; if (sda_bus !== 1'b0) $display("FAIL rm_ack_driven: got %b want 0", sda_bus); else n_pass++;
    rst_n = 1'b0;
    #1;
    obs = {sda_bus, tx_load, rx_data, rx_valid, addr_hit, rw, busy};
    n_checks++;
    if (obs !== 14'b1_0_00000000_0_0_0_0) $display("FAIL rm_async_reset: got %b want %b", obs, 14'b1_0_00000000_0_0_0_0);
    else n_pass++;
    #QTR rst_n = 1'b1;
    #QTR m_scl = 1'b1;
    #QTR;
    n_checks++; if (busy !== 1'b0) $display("FAIL rm_idle_busy: got %b want 0", busy); else n_pass++;
    base = rx_log.size();
    d = 8'($urandom);
    bus_start();
    bus_write_byte(8'h84, ack);
    n_checks++; if (ack !== 1'b1) $display("FAIL rm_readdr_ack: got %b want 1", ack); else n_pass++;
    bus_write_byte(d, ack);
    bus_stop();
    n_checks++;
    if (ack !== 1'b1 || rx_log.size() - base != 1 || rx_data !== d)
      $display("FAIL rm_rewrite: got ack %b count %0d data %h want 1 1 %h", ack, rx_log.size() - base, rx_data, d);
    else n_pass++;
  endtask

  task automatic test_general_call();
    logic ack;
    logic [7:0] last;
    int base;
    base = rx_log.size();
    bus_start();
    bus_write_byte(8'h00, ack);
    n_checks++; if (ack !== GC_EN) $display("FAIL gc_addr_ack: got %b want %b", ack, GC_EN); else n_pass++;
    n_checks++; if ({addr_hit, rw} !== {GC_EN, 1'b0}) $display("FAIL gc_hit_rw: got %b want %b0", {addr_hit, rw}, GC_EN); else n_pass++;
    bus_write_byte(8'h06, ack);
    n_checks++; if (ack !== GC_EN) $display("FAIL gc_data_ack: got %b want %b", ack, GC_EN); else n_pass++;
    bus_stop();
    last = (rx_log.size() > base) ? rx_log[$] : 8'h00;
    n_checks++;
    if (rx_log.size() - base != int'(GC_EN) || last !== (GC_EN ? 8'h06 : 8'h00))
      $display("FAIL gc_rx: got count %0d data %h want count %0d", rx_log.size() - base, last, int'(GC_EN));
    else n_pass++;
  endtask

  task automatic test_random();
    logic ack, is_rd, exp_ack;
    logic [6:0] a7;
    logic [7:0] ab, d;
    logic [7:0] bytes[4];
    int nb, base_rx, base_tx;
    for (int t = 0; t < 5; t++) begin
      is_rd = 1'($urandom_range(0, 1));
      a7 = ($urandom_range(0, 2) != 0) ? TGT : 7'($urandom_range(0, 127));
      nb = $urandom_range(1, 3);
      for (int k = 0; k < 4; k++) bytes[k] = 8'($urandom);
      ab = {a7, is_rd};
      exp_ack = model_addr_ack(ab);
      base_rx = rx_log.size();
      base_tx = tx_loads;
      tx_data = bytes[0];
      bus_start();
      bus_write_byte(ab, ack);
      n_checks++; if (ack !== exp_ack) $display("FAIL rnd%0d_addr_ack %h: got %b want %b", t, ab, ack, exp_ack); else n_pass++;
      if (exp_ack && !is_rd) begin
        for (int k = 0; k < nb; k++) begin
          bus_write_byte(bytes[k], ack);
          n_checks++; if (ack !== 1'b1) $display("FAIL rnd%0d_wack%0d: got %b want 1", t, k, ack); else n_pass++;
        end
      end else if (exp_ack) begin
        for (int k = 0; k < nb; k++) begin
          bus_read_byte(bytes[k+1], (k < nb - 1), d);
          n_checks++; if (d !== bytes[k]) $display("FAIL rnd%0d_rd%0d: got %h want %h", t, k, d, bytes[k]); else n_pass++;
        end
      end
      n_checks++; if (addr_hit !== exp_ack) $display("FAIL rnd%0d_hit: got %b want %b", t, addr_hit, exp_ack); else n_pass++;
      bus_stop();
      n_checks++; if ({busy, addr_hit} !== 2'b00) $display("FAIL rnd%0d_stop: got %b want 00", t, {busy, addr_hit}); else n_pass++;
      n_checks++;
      if (rx_log.size() - base_rx != ((exp_ack && !is_rd) ? nb : 0))
        $display("FAIL rnd%0d_rx_count: got %0d want %0d", t, rx_log.size() - base_rx, (exp_ack && !is_rd) ? nb : 0);
      else n_pass++;
      for (int k = 0; k < rx_log.size() - base_rx && k < nb; k++) begin
        n_checks++; if (rx_log[base_rx+k] !== bytes[k]) $display("FAIL rnd%0d_rx%0d: got %h want %h", t, k, rx_log[base_rx+k], bytes[k]); else n_pass++;
      end
      n_checks++;
      if (tx_loads - base_tx != ((exp_ack && is_rd) ? nb : 0))
        $display("FAIL rnd%0d_tx_loads: got %0d want %0d", t, tx_loads - base_tx, (exp_ack && is_rd) ? nb : 0);
      else n_pass++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    m_scl = 1'b1;
    m_sda_low = 1'b0;
    tx_data = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_nomatch();
    test_repeated_start();
    test_reset_mid();
    test_general_call();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
